// File: rtl/grid_pkg.sv
// Grid geometry shared by the solver, readout and print paths; mirrors grid_dimensions.svh.
// Also carries the tile value types and the readout FSM state encoding.
`ifndef GRID_ORD
`define GRID_ORD 3
`endif

package grid_pkg;

  localparam int GRID_ORD  = `GRID_ORD;
  localparam int GRID_LEN  = GRID_ORD * GRID_ORD;
  localparam int GRID_AREA = GRID_LEN * GRID_LEN;
  localparam int VAL_W     = $clog2(GRID_LEN + 1);

  typedef logic [GRID_LEN-1:0] value_onehot_t;
  typedef logic [VAL_W-1:0]    value_bin_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PEND,
    RD_STREAM,
    RD_FIN
  } rd_state_t;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot tile value to binary 1..LEN, 0 with err set when not exactly one bit is hot.
// Purely combinational, no latency, no handshake.
module onehot_to_bin
  import grid_pkg::*;
#(
  parameter int LEN = grid_pkg::GRID_LEN,
  parameter int W   = $clog2(LEN + 1)
) (
  input  logic [LEN-1:0] onehot,
  output logic [W-1:0]   value,
  output logic           err
);

  logic [W-1:0] cnt;
  logic [W-1:0] enc;

  always_comb begin
    cnt = '0;
    enc = '0;
    for (int i = 0; i < LEN; i++) begin
      if (onehot[i]) begin
        cnt = cnt + W'(1);
        enc = W'(i + 1);
      end
    end
    err   = (cnt != W'(1));
    value = err ? '0 : enc;
  end

endmodule

// File: rtl/grid_readout.sv
// Streams the solved grid one tile per beat (row-major) after rd_req; first beat the cycle after
// the accepted request, one beat per cycle with out_ready high; beats hold while out_ready is low.
module grid_readout
  import grid_pkg::*;
#(
  parameter  int GRID_ORD  = grid_pkg::GRID_ORD,
  parameter  int VAL_W     = $clog2(GRID_ORD * GRID_ORD + 1),
  localparam int GRID_LEN  = GRID_ORD * GRID_ORD,
  localparam int GRID_AREA = GRID_LEN * GRID_LEN,
  localparam int POS_W     = $clog2(GRID_LEN)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          grid_done,
  input  logic                          grid_success,
  input  logic [GRID_AREA*GRID_LEN-1:0] values,
  input  logic                          rd_req,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VAL_W-1:0]              out_value,
  output logic [POS_W-1:0]              out_row,
  output logic [POS_W-1:0]              out_col,
  output logic                          out_last,
  output logic                          out_err,
  output logic                          rd_busy,
  output logic                          rd_done,
  output logic                          rd_fail
);

  localparam int IDX_W = $clog2(GRID_AREA);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID_AREA - 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(GRID_LEN - 1);

  rd_state_t        state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [POS_W-1:0] row_q, row_d;
  logic [POS_W-1:0] col_q, col_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic             xfer;

  logic [GRID_LEN-1:0] tiles [GRID_AREA];
  logic [GRID_LEN-1:0] tile_sel;

  for (genvar i = 0; i < GRID_AREA; i++) begin : g_tile
    assign tiles[i] = values[i*GRID_LEN +: GRID_LEN];
  end

  assign tile_sel = tiles[index_q];

  onehot_to_bin #(
    .LEN (GRID_LEN),
    .W   (VAL_W)
  ) u_dec (
    .onehot (tile_sel),
    .value  (out_value),
    .err    (out_err)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RD_IDLE;
      index_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign out_valid = (state_q == RD_STREAM);
  assign xfer      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = done_q;
    fail_d  = fail_q;
    unique case (state_q)
      RD_IDLE, RD_FIN: begin
        if (rd_req) begin
          done_d  = 1'b0;
          fail_d  = 1'b0;
          index_d = '0;
          row_d   = '0;
          col_d   = '0;
          if (!grid_done) begin
            state_d = RD_PEND;
          end else if (grid_success) begin
            state_d = RD_STREAM;
          end else begin
            state_d = RD_FIN;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end
        end
      end
      RD_PEND: begin
        if (grid_done) begin
          if (grid_success) begin
            state_d = RD_STREAM;
          end else begin
            state_d = RD_FIN;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end
        end
      end
      RD_STREAM: begin
        // Solver reset under us: the held values are gone, so abort rather than stream garbage.
        if (!grid_done) begin
          state_d = RD_FIN;
          done_d  = 1'b1;
          fail_d  = 1'b1;
        end else if (xfer) begin
          if (index_q == LAST_IDX) begin
            state_d = RD_FIN;
            done_d  = 1'b1;
            fail_d  = 1'b0;
          end else begin
            index_d = index_q + IDX_W'(1);
            if (col_q == LAST_POS) begin
              col_d = '0;
              row_d = row_q + POS_W'(1);
            end else begin
              col_d = col_q + POS_W'(1);
            end
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign out_row  = row_q;
  assign out_col  = col_q;
  assign out_last = out_valid & (index_q == LAST_IDX);
  assign rd_busy  = (state_q == RD_PEND) | (state_q == RD_STREAM);
  assign rd_done  = done_q;
  assign rd_fail  = fail_q;

endmodule
